mlp_job_seq: RTL and testbench
==============================

MLP_JOB_SEQ -- requirements
Module: mlp_job_seq

Interface
REQ-001 Parameter N_INPUTS, default 2: input vector length of the attached mlp.
REQ-002 Parameter N_HIDDEN, default 4: hidden neurons.
REQ-003 Parameter N_OUTPUT, default 1: output neurons.
REQ-004 Parameter OUT_WIDTH, default 16: result width.
REQ-005 Parameter MEM_AW, default 8: job-memory word-address width.
REQ-006 Parameter TIMEOUT, default 4096: maximum cycles waited for mlp_irq.
REQ-007 Ports (clk, rst first), listed as name direction width meaning:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  job request.
- base_addr  in  MEM_AW  first word of the job.
- start_ready  out  1  high only in IDLE.
- mem_rd  out  1  job-memory read strobe.
- mem_addr  out  MEM_AW  job-memory address.
- mem_rdata  in  32  read data, valid the cycle after mem_rd.
- mlp_write_en  out  1  mlp register write.
- mlp_addr  out  2  mlp register select.
- mlp_writedata  out  32  mlp write data.
- mlp_readdata  in  32  mlp read data.
- mlp_irq  in  1  mlp done.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_data  out  OUT_WIDTH  result.
- busy  out  1  not IDLE.
- err_timeout  out  1  one-cycle pulse on timeout abort.

Function
REQ-008 The job-memory layout from base_addr SHALL be N_INPUTS inputs, then N_HIDDEN*(N_INPUTS+1) hidden words (bias first per neuron), then N_OUTPUT*(N_HIDDEN+1) output words (bias first); the default total is 19 words.
REQ-009 A start SHALL be accepted when start && start_ready; base_addr SHALL be latched on that edge, and start at any other time SHALL be ignored.
REQ-010 FSM states SHALL be IDLE, LD_IN, LD_HID, SWITCH, LD_OUT, RUN, WAIT, READ, RESULT.
REQ-011 Each loaded word SHALL take 3 cycles: RD (mem_rd=1 with mem_addr), WR (mlp_write_en=1 and mlp_writedata=mem_rdata), then GAP (mlp_write_en=0).
REQ-012 mlp_addr SHALL be 1 in LD_IN, 2 in LD_HID and 2 in LD_OUT.
REQ-013 mem_addr SHALL increment by one per word and wrap modulo 2^MEM_AW.
REQ-014 SWITCH SHALL write 0x8 to address 0; RUN SHALL write 0x1 to address 0; each of these takes 2 cycles (WR, then GAP).
REQ-015 With acceptance in cycle 0 and defaults, the first mem_rd SHALL occur in cycle 1 and the RUN write pulse in cycle 60.
REQ-016 In WAIT, the sequencer SHALL count cycles from 0; mlp_irq=1 SHALL move it to READ.
REQ-017 If the WAIT count reaches TIMEOUT, the sequencer SHALL write 0x0 to address 0, pulse err_timeout, produce no result and return to IDLE.
REQ-018 READ SHALL write to address 3 (WR, GAP) and capture mlp_readdata[OUT_WIDTH-1:0] into res_data on the cycle after GAP.
REQ-019 For each of the N_OUTPUT results, the sequencer SHALL repeat READ then RESULT.
REQ-020 In RESULT, res_valid SHALL hold and res_data SHALL stay stable until res_ready; on the handshake edge the FSM SHALL go to the next READ, or to IDLE after the last result.
REQ-021 res_valid && res_ready in the same cycle SHALL complete the transfer; start_ready SHALL rise the cycle after the last transfer.
REQ-022 mlp_write_en SHALL never be high on two consecutive cycles.
REQ-023 mlp_irq outside WAIT SHALL be ignored.

Reset
REQ-024 On rst, the FSM SHALL be IDLE.
REQ-025 On rst, these outputs SHALL be 0: mem_rd, mem_addr, mlp_write_en, mlp_addr, mlp_writedata, res_valid, res_data, busy, err_timeout.
REQ-026 On rst, start_ready SHALL be 1.
REQ-027 Reset mid-job SHALL abort immediately with no further mlp or memory accesses.
REQ-028 rst SHALL take priority over every other input on the same edge.

Structure
REQ-029 Shared package mlp_pkg SHALL hold the mlp register addresses (CTRL=0, IN=1, WGT=2, OUT=3), the control values (RUN=0x1, LAYER=0x8, CLR=0x0) and the FSM state enumeration.
REQ-030 The timeout counter SHALL be one sub-module, mlp_wdog (clear, enable, expire).

Verification
REQ-031 Inputs [7,-3]; hidden rows {1,2,3},{0,-1,2},{-2,4,1},{1,1,1}; output {1,1,1,1,1}; base 0; real mlp attached -> write sequence addr 1,1, 2 x12, 0(0x8), 2 x5, 0(0x1), 3, and res_data=35.
REQ-032 Same job with res_ready held low 10 cycles -> res_valid held, res_data=35 stable, start_ready=0 until accepted.
REQ-033 mlp_irq tied 0, TIMEOUT=64 -> write 0x0 to address 0, err_timeout high exactly 1 cycle, no res_valid, then IDLE.
REQ-034 Back-to-back jobs at base 0 and base 32, with start also pulsed while busy -> exactly two results, and mem_addr ranges 0-18 then 32-50.
REQ-035 rst asserted in LD_HID at the 5th hidden word -> all outputs at reset values the next cycle and no writes after; a fresh job then returns 35.
REQ-036 Output weights {0,2000,2000,2000,2000} with hidden values giving a sum above 32767 -> res_data=32767 (mlp saturation passed through unchanged).

Source files
------------

// File: rtl/mlp_pkg.sv
// mlp_pkg -- shared definitions for the mlp job sequencer.
// Holds the register map of the attached mlp, the control-register
// command values, the sequencer state/phase encodings and a couple of
// small sizing helpers used to derive counter widths.
package mlp_pkg;

  // mlp register addresses
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_IN   = 2'd1;
  localparam logic [1:0] REG_WGT  = 2'd2;
  localparam logic [1:0] REG_OUT  = 2'd3;

  // values written to REG_CTRL
  localparam logic [31:0] CTRL_RUN   = 32'h0000_0001;
  localparam logic [31:0] CTRL_LAYER = 32'h0000_0008;
  localparam logic [31:0] CTRL_CLR   = 32'h0000_0000;

  typedef enum logic [3:0] {
    IDLE,
    LD_IN,
    LD_HID,
    SWITCH,
    LD_OUT,
    RUN,
    WAIT,
    READ,
    RESULT
  } seq_state_t;

  // Sub-step inside a state. Word loads use RD -> WR -> GAP; single
  // register writes use WR -> GAP; WAIT uses RD as "waiting for irq"
  // and WR as the timeout abort write.
  typedef enum logic [1:0] {
    PH_RD,
    PH_WR,
    PH_GAP
  } phase_t;

  // Words of one layer in job memory: each row holds a bias plus one
  // weight per input of that layer.
  function automatic int section_words(int n_rows, int n_cols);
    return n_rows * (n_cols + 1);
  endfunction

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mlp_job_seq_if.sv
// mlp_job_seq_if -- all handshake and bus signals of the job sequencer.
//   job request : start, base_addr, start_ready, busy
//   job memory  : mem_rd, mem_addr, mem_rdata (data one cycle after mem_rd)
//   mlp bus     : mlp_write_en, mlp_addr, mlp_writedata, mlp_readdata, mlp_irq
//   result      : res_valid, res_ready, res_data
//   status      : err_timeout (one-cycle pulse on a timeout abort)
// modport master is the sequencer side, modport slave the environment.
interface mlp_job_seq_if #(
  parameter int MEM_AW    = 8,
  parameter int OUT_WIDTH = 16
);
  logic                 start;
  logic [MEM_AW-1:0]    base_addr;
  logic                 start_ready;
  logic                 mem_rd;
  logic [MEM_AW-1:0]    mem_addr;
  logic [31:0]          mem_rdata;
  logic                 mlp_write_en;
  logic [1:0]           mlp_addr;
  logic [31:0]          mlp_writedata;
  logic [31:0]          mlp_readdata;
  logic                 mlp_irq;
  logic                 res_valid;
  logic                 res_ready;
  logic [OUT_WIDTH-1:0] res_data;
  logic                 busy;
  logic                 err_timeout;

  modport master (
    input  start, base_addr, mem_rdata, mlp_readdata, mlp_irq, res_ready,
    output start_ready, mem_rd, mem_addr, mlp_write_en, mlp_addr,
           mlp_writedata, res_valid, res_data, busy, err_timeout
  );

  modport slave (
    output start, base_addr, mem_rdata, mlp_readdata, mlp_irq, res_ready,
    input  start_ready, mem_rd, mem_addr, mlp_write_en, mlp_addr,
           mlp_writedata, res_valid, res_data, busy, err_timeout
  );
endinterface

// File: rtl/mlp_wdog.sv
// mlp_wdog -- cycle counter bounding the wait for the mlp done interrupt.
//   clk, rst : clock and synchronous active-high reset
//   clear    : force the count back to zero
//   enable   : count one cycle
//   expire   : high while enabled in the TIMEOUT-th counted cycle
module mlp_wdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable && !expire) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expire = enable && (count_reg == LAST);
endmodule

// File: rtl/mlp_job_seq.sv
// mlp_job_seq -- streams one job (inputs, hidden weights, output weights)
// from job memory into an attached mlp, starts it, waits for its done
// interrupt (bounded by a watchdog) and hands each output back through a
// valid/ready result port.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mlp_job_seq_if.master carrying the job request, job memory,
//              mlp register bus, result handshake and status signals
module mlp_job_seq #(
  parameter int N_INPUTS  = 2,
  parameter int N_HIDDEN  = 4,
  parameter int N_OUTPUT  = 1,
  parameter int OUT_WIDTH = 16,
  parameter int MEM_AW    = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic           clk,
  input  logic           rst,
  mlp_job_seq_if.master  bus
);
  import mlp_pkg::*;

  localparam int IN_WORDS  = N_INPUTS;
  localparam int HID_WORDS = section_words(N_HIDDEN, N_INPUTS);
  localparam int OUT_WORDS = section_words(N_OUTPUT, N_HIDDEN);
  localparam int CNT_MAX   = max3(IN_WORDS, HID_WORDS, OUT_WORDS);
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int OIW       = $clog2(N_OUTPUT + 1);

  localparam logic [CW-1:0]  IN_LAST   = CW'(IN_WORDS - 1);
  localparam logic [CW-1:0]  HID_LAST  = CW'(HID_WORDS - 1);
  localparam logic [CW-1:0]  OUT_LAST  = CW'(OUT_WORDS - 1);
  localparam logic [OIW-1:0] LAST_RES  = OIW'(N_OUTPUT - 1);

  seq_state_t           state_reg, state_next;
  phase_t               phase_reg, phase_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [MEM_AW-1:0]    addr_reg, addr_next;
  logic [OIW-1:0]       out_idx_reg, out_idx_next;
  logic [OUT_WIDTH-1:0] res_data_reg, res_data_next;
  logic [CW-1:0]        sec_last;
  logic                 wdog_clear, wdog_enable, wdog_expire;

  mlp_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wdog_clear),
    .enable (wdog_enable),
    .expire (wdog_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      phase_reg    <= PH_RD;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      out_idx_reg  <= '0;
      res_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      cnt_reg      <= cnt_next;
      addr_reg     <= addr_next;
      out_idx_reg  <= out_idx_next;
      res_data_reg <= res_data_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    phase_next        = phase_reg;
    cnt_next          = cnt_reg;
    addr_next         = addr_reg;
    out_idx_next      = out_idx_reg;
    res_data_next     = res_data_reg;
    sec_last          = OUT_LAST;
    wdog_clear        = 1'b1;
    wdog_enable       = 1'b0;
    bus.mem_rd        = 1'b0;
    bus.mlp_write_en  = 1'b0;
    bus.mlp_addr      = REG_CTRL;
    bus.mlp_writedata = '0;
    bus.res_valid     = 1'b0;
    bus.err_timeout   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next   = LD_IN;
          phase_next   = PH_RD;
          cnt_next     = '0;
          addr_next    = bus.base_addr;
          out_idx_next = '0;
        end
      end

      LD_IN, LD_HID, LD_OUT: begin
        bus.mlp_addr = (state_reg == LD_IN) ? REG_IN : REG_WGT;
        if (state_reg == LD_IN) begin
          sec_last = IN_LAST;
        end else if (state_reg == LD_HID) begin
          sec_last = HID_LAST;
        end
        case (phase_reg)
          PH_RD: begin
            bus.mem_rd = 1'b1;
            // address advances as soon as the read is issued; wraps freely
            addr_next  = addr_reg + 1'b1;
            phase_next = PH_WR;
          end
          PH_WR: begin
            bus.mlp_write_en  = 1'b1;
            bus.mlp_writedata = bus.mem_rdata;
            phase_next        = PH_GAP;
          end
          default: begin
            phase_next = PH_RD;
            if (cnt_reg == sec_last) begin
              cnt_next = '0;
              case (state_reg)
                LD_IN: state_next = LD_HID;
                LD_HID: begin
                  state_next = SWITCH;
                  phase_next = PH_WR;
                end
                default: begin
                  state_next = RUN;
                  phase_next = PH_WR;
                end
              endcase
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        endcase
      end

      SWITCH: begin
        if (phase_reg == PH_WR) begin
          bus.mlp_write_en  = 1'b1;
          bus.mlp_writedata = CTRL_LAYER;
          phase_next        = PH_GAP;
        end else begin
          state_next = LD_OUT;
          phase_next = PH_RD;
        end
      end

      RUN: begin
        if (phase_reg == PH_WR) begin
          bus.mlp_write_en  = 1'b1;
          bus.mlp_writedata = CTRL_RUN;
          phase_next        = PH_GAP;
        end else begin
          state_next = WAIT;
          phase_next = PH_RD;
        end
      end

      WAIT: begin
        wdog_clear = 1'b0;
        if (phase_reg == PH_RD) begin
          wdog_enable = 1'b1;
          // a done interrupt in the very cycle the watchdog expires still wins
          if (bus.mlp_irq) begin
            state_next = READ;
            phase_next = PH_WR;
          end else if (wdog_expire) begin
            phase_next = PH_WR;
          end
        end else begin
          // timeout abort: clear the mlp and drop the job without a result
          bus.mlp_write_en  = 1'b1;
          bus.mlp_writedata = CTRL_CLR;
          bus.err_timeout   = 1'b1;
          state_next        = IDLE;
          phase_next        = PH_RD;
        end
      end

      READ: begin
        bus.mlp_addr = REG_OUT;
        if (phase_reg == PH_WR) begin
          bus.mlp_write_en  = 1'b1;
          bus.mlp_writedata = 32'(out_idx_reg);
          phase_next        = PH_GAP;
        end else begin
          // readdata is valid in the GAP cycle; it becomes res_data next cycle
          res_data_next = bus.mlp_readdata[OUT_WIDTH-1:0];
          state_next    = RESULT;
          phase_next    = PH_RD;
        end
      end

      RESULT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          if (out_idx_reg == LAST_RES) begin
            state_next = IDLE;
          end else begin
            out_idx_next = out_idx_reg + 1'b1;
            state_next   = READ;
            phase_next   = PH_WR;
          end
        end
      end

      default: begin
        state_next = IDLE;
        phase_next = PH_RD;
      end
    endcase
  end

  assign bus.mem_addr    = addr_reg;
  assign bus.res_data    = res_data_reg;
  assign bus.start_ready = (state_reg == IDLE);
  assign bus.busy        = (state_reg != IDLE);

  // only the low OUT_WIDTH bits of the mlp result are meaningful
  generate
    if (OUT_WIDTH < 32) begin : g_rd_unused
      logic unused_rd_bits;
      assign unused_rd_bits = ^bus.mlp_readdata[31:OUT_WIDTH];
    end
  endgenerate
endmodule

// File: tb/tb_mlp_job_seq.sv
// tb_mlp_job_seq -- directed bench for mlp_job_seq with a job memory and a
// behavioural mlp (ReLU hidden layer, 16-bit saturating output) attached.
`timescale 1ns/1ps
module tb_mlp_job_seq;
  localparam int N_IN  = 2;
  localparam int N_HID = 4;
  localparam int N_OUT = 1;
  localparam int OW    = 16;
  localparam int AW    = 8;
  localparam int TO    = 64;

  logic clk = 1'b0;
  logic rst;
  bit   irq_en;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mlp_job_seq_if #(.MEM_AW(AW), .OUT_WIDTH(OW)) bus ();

  mlp_job_seq #(
    .N_INPUTS(N_IN), .N_HIDDEN(N_HID), .N_OUTPUT(N_OUT),
    .OUT_WIDTH(OW), .MEM_AW(AW), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- job memory (registered read) ----------------
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // ---------------- behavioural mlp ----------------
  logic signed [31:0] in_buf [N_IN];
  logic signed [31:0] hw [64];
  logic signed [31:0] ow [64];
  logic signed [31:0] out_val [N_OUT];
  int in_cnt, w_cnt, irq_cnt, out_sel;
  bit layer;

  function automatic logic signed [31:0] mlp_eval(int j);
    logic signed [31:0] h;
    logic signed [63:0] acc;
    acc = 64'(ow[j*(N_HID+1)]);
    for (int k = 0; k < N_HID; k++) begin
      h = hw[k*(N_IN+1)];
      for (int i = 0; i < N_IN; i++) h = h + hw[k*(N_IN+1)+1+i] * in_buf[i];
      if (h < 0) h = 0;
      acc = acc + 64'(ow[j*(N_HID+1)+1+k]) * 64'(h);
    end
    if (acc > 64'sd32767) acc = 64'sd32767;
    else if (acc < -64'sd32768) acc = -64'sd32768;
    return acc[31:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      in_cnt <= 0; w_cnt <= 0; layer <= 1'b0; irq_cnt <= 0; out_sel <= 0;
      bus.mlp_irq <= 1'b0;
    end else begin
      if (irq_cnt != 0) begin
        irq_cnt <= irq_cnt - 1;
        if (irq_cnt == 1 && irq_en) bus.mlp_irq <= 1'b1;
      end
      if (bus.mlp_write_en) begin
        case (bus.mlp_addr)
          2'd1: begin
            in_buf[in_cnt % N_IN] <= bus.mlp_writedata;
            in_cnt <= in_cnt + 1;
          end
          2'd2: begin
            if (layer) ow[w_cnt % 64] <= bus.mlp_writedata;
            else       hw[w_cnt % 64] <= bus.mlp_writedata;
            w_cnt <= w_cnt + 1;
          end
          2'd0: begin
            if (bus.mlp_writedata == 32'h8) begin
              layer <= 1'b1; w_cnt <= 0;
            end else if (bus.mlp_writedata == 32'h1) begin
              for (int j = 0; j < N_OUT; j++) out_val[j] <= mlp_eval(j);
              irq_cnt <= 5;
            end else begin
              in_cnt <= 0; w_cnt <= 0; layer <= 1'b0; irq_cnt <= 0;
              bus.mlp_irq <= 1'b0;
            end
          end
          default: begin
            out_sel <= int'(bus.mlp_writedata) % N_OUT;
            in_cnt <= 0; w_cnt <= 0; layer <= 1'b0;
            bus.mlp_irq <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.mlp_readdata = out_val[out_sel];

  // ---------------- monitor (samples mid-cycle) ----------------
  int cyc = 0, wn = 0, rn = 0, resn = 0, errn = 0, dbl_we = 0, acc_cyc = 0;
  logic [1:0]    w_addr_log [512];
  logic [31:0]   w_data_log [512];
  int            w_cyc_log  [512];
  logic [AW-1:0] r_addr_log [512];
  int            r_cyc_log  [512];
  logic [OW-1:0] res_log    [16];
  logic prev_we = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_we <= bus.mlp_write_en;
    if (bus.mlp_write_en && prev_we) dbl_we <= dbl_we + 1;
    if (bus.mlp_write_en) begin
      w_addr_log[wn % 512] <= bus.mlp_addr;
      w_data_log[wn % 512] <= bus.mlp_writedata;
      w_cyc_log[wn % 512]  <= cyc;
      wn <= wn + 1;
    end
    if (bus.mem_rd) begin
      r_addr_log[rn % 512] <= bus.mem_addr;
      r_cyc_log[rn % 512]  <= cyc;
      rn <= rn + 1;
    end
    if (bus.res_valid && bus.res_ready) begin
      res_log[resn % 16] <= bus.res_data;
      resn <= resn + 1;
    end
    if (bus.start && bus.start_ready && !rst) acc_cyc <= cyc;
    if (bus.err_timeout) errn <= errn + 1;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_job(input int b, input bit sat);
    int words [19];
    words = '{7, -3, 1, 2, 3, 0, -1, 2, -2, 4, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    if (sat) begin
      words[14] = 0;
      for (int i = 15; i < 19; i++) words[i] = 2000;
    end
    for (int i = 0; i < 19; i++) mem[(b + i) % 256] = 32'(words[i]);
  endtask

  task automatic start_job(input logic [AW-1:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.base_addr = '0;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int k;
    k = 0;
    while (!bus.start_ready && k < lim) begin
      @(posedge clk); #1; k++;
    end
    chk(tag, 32'(bus.start_ready), 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_start_ready"}, 32'(bus.start_ready), 32'd1);
    chk({tag, "_ctl"}, 32'({bus.mem_rd, bus.mlp_write_en, bus.res_valid, bus.busy, bus.err_timeout}), 32'd0);
    chk({tag, "_addr"}, 32'({bus.mem_addr, bus.mlp_addr}), 32'd0);
    chk({tag, "_wdata"}, bus.mlp_writedata, 32'd0);
    chk({tag, "_res_data"}, 32'(bus.res_data), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w0, r0, res0, e0, k, mism, hold_err, wsnap, rsnap;
    logic [1:0] ea;

    rst = 1'b1; irq_en = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.res_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    load_job(0, 1'b0);
    load_job(32, 1'b0);
    load_job(64, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst = 1'b0;

    // job at base 0: write order, data, timing and result
    w0 = wn; r0 = rn; res0 = resn;
    start_job(0);
    wait_idle("job1_idle", 300);
    chk("job1_nwrites", 32'(wn - w0), 32'd22);
    mism = 0;
    for (int i = 0; i < 22; i++) begin
      if (i < 2) ea = 2'd1;
      else if (i < 14) ea = 2'd2;
      else if (i == 14) ea = 2'd0;
      else if (i < 20) ea = 2'd2;
      else if (i == 20) ea = 2'd0;
      else ea = 2'd3;
      if (w_addr_log[(w0 + i) % 512] !== ea) mism++;
    end
    chk("job1_write_addr_seq", 32'(mism), 32'd0);
    chk("job1_in0", w_data_log[(w0 + 0) % 512], 32'd7);
    chk("job1_in1", w_data_log[(w0 + 1) % 512], 32'hFFFF_FFFD);
    chk("job1_layer_cmd", w_data_log[(w0 + 14) % 512], 32'h8);
    chk("job1_run_cmd", w_data_log[(w0 + 20) % 512], 32'h1);
    chk("job1_first_rd_cycle", 32'(r_cyc_log[r0 % 512] - acc_cyc), 32'd1);
    chk("job1_run_cycle", 32'(w_cyc_log[(w0 + 20) % 512] - acc_cyc), 32'd60);
    chk("job1_nresults", 32'(resn - res0), 32'd1);
    chk("job1_result", 32'(res_log[res0 % 16]), 32'd35);

    // result held while res_ready is low
    bus.res_ready = 1'b0;
    res0 = resn;
    start_job(0);
    k = 0;
    while (!bus.res_valid && k < 300) begin
      @(posedge clk); #1; k++;
    end
    chk("hold_valid_seen", 32'(bus.res_valid), 32'd1);
    hold_err = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 16'd35 || bus.start_ready !== 1'b0)
        hold_err++;
    end
    chk("hold_stable", 32'(hold_err), 32'd0);
    chk("hold_data", 32'(bus.res_data), 32'd35);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("hold_start_ready_after", 32'(bus.start_ready), 32'd1);
    chk("hold_nresults", 32'(resn - res0), 32'd1);
    bus.res_ready = 1'b1;

    // back-to-back jobs with a stray start while busy
    r0 = rn; res0 = resn;
    start_job(0);
    repeat (20) @(posedge clk);
    start_job(8'd100);
    wait_idle("b2b_idle1", 300);
    start_job(8'd32);
    wait_idle("b2b_idle2", 300);
    chk("b2b_nresults", 32'(resn - res0), 32'd2);
    chk("b2b_nreads", 32'(rn - r0), 32'd38);
    mism = 0;
    for (int i = 0; i < 38; i++) begin
      if (r_addr_log[(r0 + i) % 512] !== ((i < 19) ? AW'(i) : AW'(32 + i - 19))) mism++;
    end
    chk("b2b_read_addrs", 32'(mism), 32'd0);
    chk("b2b_result1", 32'(res_log[res0 % 16]), 32'd35);
    chk("b2b_result2", 32'(res_log[(res0 + 1) % 16]), 32'd35);

    // reset during the 5th hidden word (job address 6)
    start_job(0);
    k = 0;
    while (!(bus.mem_rd && bus.mem_addr == 8'd6) && k < 200) begin
      @(posedge clk); #1; k++;
    end
    chk("midrst_reached_word", 32'(bus.mem_addr), 32'd6);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outs("midrst");
    wsnap = wn; rsnap = rn;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_writes", 32'(wn - wsnap), 32'd0);
    chk("midrst_no_reads", 32'(rn - rsnap), 32'd0);
    res0 = resn;
    start_job(0);
    wait_idle("midrst_fresh_idle", 300);
    chk("midrst_fresh_result", 32'(res_log[res0 % 16]), 32'd35);

    // saturating output
    res0 = resn;
    start_job(8'd64);
    wait_idle("sat_idle", 300);
    chk("sat_result", 32'(res_log[res0 % 16]), 32'd32767);

    // timeout: mlp never signals done
    irq_en = 1'b0;
    e0 = errn; res0 = resn; w0 = wn;
    start_job(0);
    k = 0;
    while (!bus.err_timeout && k < 400) begin
      @(posedge clk); #1; k++;
    end
    chk("to_err_seen", 32'(bus.err_timeout), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("to_err_one_cycle", 32'(errn - e0), 32'd1);
    chk("to_no_result", 32'(resn - res0), 32'd0);
    chk("to_nwrites", 32'(wn - w0), 32'd22);
    chk("to_clr_addr", 32'(w_addr_log[(wn - 1) % 512]), 32'd0);
    chk("to_clr_data", w_data_log[(wn - 1) % 512], 32'd0);
    chk("to_idle", 32'(bus.start_ready), 32'd1);
    irq_en = 1'b1;

    chk("no_back_to_back_writes", 32'(dbl_we), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
